// File: rtl/pwm_shadow_ctrl.sv
// Shadow/active register set for a PWM carrier: host writes land in a shadow
// copy and are committed to the active set on masked, prescaled carrier events.
module pwm_shadow_ctrl #(
  parameter int PWMCOUNT_WIDTH = 16,
  parameter int EVTCOUNT_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pwm_en,
  input  logic                      int_en,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [PWMCOUNT_WIDTH-1:0] cfg_period,
  input  logic [PWMCOUNT_WIDTH-1:0] cfg_compare,
  input  logic [PWMCOUNT_WIDTH-1:0] cfg_initcarr,
  input  logic [1:0]                cfg_countmode,
  input  logic [1:0]                cfg_maskmode,
  input  logic [EVTCOUNT_WIDTH-1:0] cfg_eventcount,
  input  logic                      carr_min,
  input  logic                      carr_max,
  output logic [PWMCOUNT_WIDTH-1:0] act_period,
  output logic [PWMCOUNT_WIDTH-1:0] act_compare,
  output logic [PWMCOUNT_WIDTH-1:0] act_initcarr,
  output logic [1:0]                act_countmode,
  output logic                      act_carr_en,
  output logic                      pending,
  output logic                      commit,
  output logic                      interrupt
);

  // state  | meaning
  // IDLE   | no pending data
  // PEND   | shadow loaded, waiting for qualifying events
  // COMMIT | one cycle, shadow copied to active at its end
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] MIN_MASK    = 2'd1;
  localparam logic [1:0] MAX_MASK    = 2'd2;
  localparam logic [1:0] MINMAX_MASK = 2'd3;

  state_t                    state;
  logic [EVTCOUNT_WIDTH-1:0] evt_cnt;
  logic [PWMCOUNT_WIDTH-1:0] sh_period;
  logic [PWMCOUNT_WIDTH-1:0] sh_compare;
  logic [PWMCOUNT_WIDTH-1:0] sh_initcarr;
  logic [1:0]                sh_countmode;
  logic [1:0]                sh_maskmode;
  logic [EVTCOUNT_WIDTH-1:0] sh_eventcount;
  logic                      xfer;
  logic                      qual;

  assign cfg_ready   = ~reset && (state != COMMIT);
  assign xfer        = cfg_valid && cfg_ready;
  assign pending     = (state == PEND);
  assign interrupt   = commit && int_en;
  assign act_carr_en = pwm_en && (act_period != '0);

  always_comb begin
    qual = 1'b1;
    case (sh_maskmode)
      MIN_MASK:    qual = carr_min;
      MAX_MASK:    qual = carr_max;
      MINMAX_MASK: qual = carr_min || carr_max;
      default:     qual = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      evt_cnt       <= '0;
      sh_period     <= '0;
      sh_compare    <= '0;
      sh_initcarr   <= '0;
      sh_countmode  <= '0;
      sh_maskmode   <= '0;
      sh_eventcount <= '0;
      act_period    <= '0;
      act_compare   <= '0;
      act_initcarr  <= '0;
      act_countmode <= '0;
      commit        <= 1'b0;
    end else begin
      commit <= 1'b0;
      // A write in the deciding PEND cycle still lands before the COMMIT copy.
      if (xfer) begin
        sh_period     <= cfg_period;
        sh_compare    <= cfg_compare;
        sh_initcarr   <= cfg_initcarr;
        sh_countmode  <= (cfg_countmode == 2'd3) ? 2'd0 : cfg_countmode;
        sh_maskmode   <= cfg_maskmode;
        sh_eventcount <= cfg_eventcount;
      end
      case (state)
        IDLE: begin
          if (xfer) state <= PEND;
        end
        PEND: begin
          if (!pwm_en) begin
            state   <= COMMIT;
            commit  <= 1'b1;
            evt_cnt <= '0;
          end else if (qual) begin
            if (evt_cnt == sh_eventcount) begin
              state   <= COMMIT;
              commit  <= 1'b1;
              evt_cnt <= '0;
            end else begin
              evt_cnt <= evt_cnt + EVTCOUNT_WIDTH'(1);
            end
          end
        end
        COMMIT: begin
          act_period    <= sh_period;
          act_compare   <= sh_compare;
          act_initcarr  <= sh_initcarr;
          act_countmode <= sh_countmode;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_shadow_ctrl.sv
// Directed bench for pwm_shadow_ctrl: a per-cycle vector table plus
// hand-written sequences for stop, backpressure, interrupt gating and reset.
module tb_pwm_shadow_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pwm_en, int_en, cfg_valid, cfg_ready;
  logic [15:0] cfg_period, cfg_compare, cfg_initcarr;
  logic [1:0]  cfg_countmode, cfg_maskmode;
  logic [3:0]  cfg_eventcount;
  logic        carr_min, carr_max;
  logic [15:0] act_period, act_compare, act_initcarr;
  logic [1:0]  act_countmode;
  logic        act_carr_en, pending, commit, interrupt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_shadow_ctrl #(.PWMCOUNT_WIDTH(16), .EVTCOUNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .pwm_en(pwm_en), .int_en(int_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_compare(cfg_compare), .cfg_initcarr(cfg_initcarr),
    .cfg_countmode(cfg_countmode), .cfg_maskmode(cfg_maskmode),
    .cfg_eventcount(cfg_eventcount), .carr_min(carr_min), .carr_max(carr_max),
    .act_period(act_period), .act_compare(act_compare), .act_initcarr(act_initcarr),
    .act_countmode(act_countmode), .act_carr_en(act_carr_en), .pending(pending),
    .commit(commit), .interrupt(interrupt)
  );

  typedef struct {
    logic        rst, en, ie, v;
    logic [15:0] per, cmp;
    logic [1:0]  cm, mm;
    logic [3:0]  ec;
    logic        mn, mx;
    logic        e_rdy, e_pend, e_com;
    logic [15:0] e_per;
    logic        e_cen;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic v, logic [15:0] per, logic [1:0] mm,
                              logic [3:0] ec, logic mn, logic mx, logic e_rdy,
                              logic e_pend, logic e_com, logic [15:0] e_per, logic e_cen);
    vec_t r;
    r.rst = rst; r.en = 1'b1; r.ie = 1'b1; r.v = v;
    r.per = per; r.cmp = per >> 2; r.cm = 2'd2; r.mm = mm; r.ec = ec;
    r.mn = mn; r.mx = mx;
    r.e_rdy = e_rdy; r.e_pend = e_pend; r.e_com = e_com;
    r.e_per = e_per; r.e_cen = e_cen;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0; carr_min = 1'b0; carr_max = 1'b0;
  endtask

  initial begin
    reset = 1'b1; pwm_en = 1'b1; int_en = 1'b1; cfg_valid = 1'b0;
    cfg_period = '0; cfg_compare = '0; cfg_initcarr = '0;
    cfg_countmode = '0; cfg_maskmode = '0; cfg_eventcount = '0;
    carr_min = 1'b0; carr_max = 1'b0;
    next(); next();

    //            rst v   per   mm ec mn mx  rdy pend com  per   cen
    tbl.push_back(mk(1, 0,    0, 0, 0, 0, 0,  0,  0,  0,     0, 0)); // 0 in reset
    tbl.push_back(mk(0, 1, 2000, 1, 0, 0, 0,  1,  0,  0,     0, 0)); // 1 basic transfer
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  1,  1,  0,     0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 1,  1,  1,  0,     0, 0)); // carr_max ignored
    tbl.push_back(mk(0, 0,    0, 0, 0, 1, 0,  1,  1,  0,     0, 0)); // carr_min decides
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  0,  0,  1,     0, 0)); // 5 COMMIT
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  1,  0,  0,  2000, 1));
    tbl.push_back(mk(0, 1, 3000, 1, 1, 0, 0,  1,  0,  0,  2000, 1)); // 7 prescaler
    tbl.push_back(mk(0, 0,    0, 0, 0, 1, 0,  1,  1,  0,  2000, 1)); // first min skipped
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 1,  1,  1,  0,  2000, 1));
    tbl.push_back(mk(0, 0,    0, 0, 0, 1, 0,  1,  1,  0,  2000, 1)); // second min
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  0,  0,  1,  2000, 1));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  1,  0,  0,  3000, 1));
    tbl.push_back(mk(0, 1, 1500, 1, 1, 0, 0,  1,  0,  0,  3000, 1)); // 13 overwrite
    tbl.push_back(mk(0, 0,    0, 0, 0, 1, 0,  1,  1,  0,  3000, 1)); // evt_cnt -> 1
    tbl.push_back(mk(0, 1, 1000, 1, 1, 0, 0,  1,  1,  0,  3000, 1)); // overwrite, cnt kept
    tbl.push_back(mk(0, 0,    0, 0, 0, 1, 0,  1,  1,  0,  3000, 1));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  0,  0,  1,  3000, 1));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  1,  0,  0,  1000, 1));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  1,  0,  0,  1000, 1)); // single pulse
    tbl.push_back(mk(0, 1,    0, 0, 0, 0, 0,  1,  0,  0,  1000, 1)); // 20 period 0, NO_MASK
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  1,  1,  0,  1000, 1));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  0,  0,  1,  1000, 1));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  1,  0,  0,     0, 0)); // carrier off
    tbl.push_back(mk(0, 1,  700, 1, 0, 0, 0,  1,  0,  0,     0, 0)); // 24 same-cycle write
    tbl.push_back(mk(0, 1,  800, 1, 0, 1, 0,  1,  1,  0,     0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  0,  0,  1,     0, 0));
    tbl.push_back(mk(0, 0,    0, 0, 0, 0, 0,  1,  0,  0,   800, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; pwm_en = tbl[i].en; int_en = tbl[i].ie;
      cfg_valid = tbl[i].v; cfg_period = tbl[i].per; cfg_compare = tbl[i].cmp;
      cfg_initcarr = '0; cfg_countmode = tbl[i].cm; cfg_maskmode = tbl[i].mm;
      cfg_eventcount = tbl[i].ec; carr_min = tbl[i].mn; carr_max = tbl[i].mx;
      at_neg();
      chk($sformatf("row%0d_ready", i),   cfg_ready,   tbl[i].e_rdy);
      chk($sformatf("row%0d_pending", i), pending,     tbl[i].e_pend);
      chk($sformatf("row%0d_commit", i),  commit,      tbl[i].e_com);
      chk($sformatf("row%0d_irq", i),     interrupt,   tbl[i].e_com);
      chk($sformatf("row%0d_period", i),  act_period,  tbl[i].e_per);
      chk($sformatf("row%0d_carr_en", i), act_carr_en, tbl[i].e_cen);
      next();
    end

    // Stop while pending: MAX_MASK never fires, pwm_en = 0 forces the commit.
    idle_inputs(); pwm_en = 1'b0; int_en = 1'b0;
    cfg_valid = 1'b1; cfg_period = 16'd500; cfg_compare = 16'd50; cfg_initcarr = 16'd77;
    cfg_countmode = 2'd3; cfg_maskmode = 2'd2; cfg_eventcount = 4'd5;
    at_neg(); chk("stop_pend0", pending, 1'b0); chk("stop_cen_off", act_carr_en, 1'b0);
    next(); idle_inputs();
    at_neg(); chk("stop_pend1", pending, 1'b1); chk("stop_com_early", commit, 1'b0);
    next();
    at_neg(); chk("stop_commit", commit, 1'b1); chk("stop_irq_gated", interrupt, 1'b0);
    chk("stop_ready0", cfg_ready, 1'b0);
    next();
    at_neg(); chk("stop_period", act_period, 16'd500); chk("stop_compare", act_compare, 16'd50);
    chk("stop_initcarr", act_initcarr, 16'd77); chk("stop_cmode3", act_countmode, 2'd0);
    chk("stop_cen", act_carr_en, 1'b0); chk("stop_pend_done", pending, 1'b0);
    next(); pwm_en = 1'b1;
    at_neg(); chk("stop_cen_on", act_carr_en, 1'b1); chk("stop_single", commit, 1'b0);
    next();

    // Backpressure: a set offered during COMMIT is taken on the following IDLE cycle.
    int_en = 1'b1; cfg_valid = 1'b1; cfg_period = 16'd900; cfg_maskmode = 2'd0;
    cfg_eventcount = 4'd0; cfg_countmode = 2'd1;
    at_neg(); chk("bp_pend0", pending, 1'b0);
    next(); cfg_valid = 1'b0;
    at_neg(); chk("bp_pend1", pending, 1'b1);
    next(); cfg_valid = 1'b1; cfg_period = 16'd901; cfg_maskmode = 2'd1;
    at_neg(); chk("bp_ready0", cfg_ready, 1'b0); chk("bp_commit", commit, 1'b1);
    chk("bp_irq", interrupt, 1'b1);
    next();
    at_neg(); chk("bp_ready1", cfg_ready, 1'b1); chk("bp_idle", pending, 1'b0);
    chk("bp_period900", act_period, 16'd900); chk("bp_cmode", act_countmode, 2'd1);
    next(); cfg_valid = 1'b0;
    at_neg(); chk("bp_repend", pending, 1'b1); chk("bp_nocommit", commit, 1'b0);
    next(); carr_min = 1'b1;
    at_neg(); chk("bp_wait", pending, 1'b1);
    next(); carr_min = 1'b0;
    at_neg(); chk("bp_commit2", commit, 1'b1);
    next();
    at_neg(); chk("bp_period901", act_period, 16'd901); chk("bp_done", pending, 1'b0);
    next();
    at_neg(); chk("bp_no_dup_pend", pending, 1'b0); chk("bp_no_dup_com", commit, 1'b0);
    next();

    // Reset while pending aborts the set.
    cfg_valid = 1'b1; cfg_period = 16'd1234; cfg_maskmode = 2'd1; cfg_eventcount = 4'd0;
    at_neg(); chk("rst_pend0", pending, 1'b0);
    next(); cfg_valid = 1'b0;
    at_neg(); chk("rst_pend1", pending, 1'b1);
    next(); reset = 1'b1; carr_min = 1'b1;
    at_neg(); chk("rst_ready_low", cfg_ready, 1'b0);
    next(); reset = 1'b0; carr_min = 1'b0;
    at_neg(); chk("rst_pend", pending, 1'b0); chk("rst_commit", commit, 1'b0);
    chk("rst_irq", interrupt, 1'b0); chk("rst_period", act_period, 16'd0);
    chk("rst_compare", act_compare, 16'd0); chk("rst_initcarr", act_initcarr, 16'd0);
    chk("rst_cmode", act_countmode, 2'd0); chk("rst_cen", act_carr_en, 1'b0);
    chk("rst_ready1", cfg_ready, 1'b1);
    next(); carr_min = 1'b1;
    at_neg(); chk("rst_min_ignored", pending, 1'b0);
    next(); carr_min = 1'b0;
    at_neg(); chk("rst_no_commit", commit, 1'b0); chk("rst_period_kept", act_period, 16'd0);
    next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_shadow_ctrl.md
PWM_SHADOW_CTRL -- requirements
Module: pwm_shadow_ctrl

Interface
REQ-001 Parameter PWMCOUNT_WIDTH, default 16: width of period, compare and initial-carrier words.
REQ-002 Parameter EVTCOUNT_WIDTH, default 4: width of the event-count prescaler.
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 pwm_en  in  1  1 = carrier running (PWM_ON), 0 = stopped (PWM_OFF).
REQ-006 int_en  in  1  1 = interrupt enabled (INT_ON).
REQ-007 cfg_valid  in  1  host offers a new configuration set.
REQ-008 cfg_ready  out  1  block accepts the set this cycle.
REQ-009 cfg_period, cfg_compare, cfg_initcarr  in  PWMCOUNT_WIDTH each  new period, compare and carrier start value.
REQ-010 cfg_countmode  in  2  0 = COUNT_UP, 1 = COUNT_DOWN, 2 = COUNT_UPDOWN; 3 is reserved and treated as 0.
REQ-011 cfg_maskmode  in  2  0 = NO_MASK, 1 = MIN_MASK, 2 = MAX_MASK, 3 = MINMAX_MASK.
REQ-012 cfg_eventcount  in  EVTCOUNT_WIDTH  number of qualifying carrier events to skip before a commit.
REQ-013 carr_min, carr_max  in  1 each  one-cycle pulses from the carrier when it reaches 0 or the period.
REQ-014 act_period, act_compare, act_initcarr  out  PWMCOUNT_WIDTH each  active values driving the carrier and comparator.
REQ-015 act_countmode  out  2  active count mode.
REQ-016 act_carr_en  out  1  carrier enable; 1 when pwm_en = 1 and act_period != 0.
REQ-017 pending  out  1  the shadow set holds data not yet committed.
REQ-018 commit  out  1  one-cycle pulse in the cycle the active registers load.
REQ-019 interrupt  out  1  one-cycle pulse equal to commit AND int_en.

Function
REQ-020 The block SHALL implement an FSM with three states:
- IDLE: no pending data.
- PEND: shadow loaded, waiting for qualifying events.
- COMMIT: one cycle; copies shadow to active.
REQ-021 cfg_ready SHALL be 1 in IDLE and PEND and 0 in COMMIT.
REQ-022 A transfer occurs when cfg_valid = 1 and cfg_ready = 1; all cfg_* fields latch into the shadow set.
- From IDLE: FSM goes to PEND.
- In PEND: the shadow set is overwritten; the event counter is not reset.
REQ-023 Qualifying event by shadow maskmode:
- MIN_MASK: carr_min.
- MAX_MASK: carr_max.
- MINMAX_MASK: carr_min OR carr_max.
- NO_MASK: every cycle.
REQ-024 In PEND, each qualifying event SHALL increment evt_cnt; when evt_cnt reaches shadow eventcount, the next qualifying event moves the FSM to COMMIT.
- A commit therefore happens on the (eventcount+1)-th qualifying event.
- evt_cnt is EVTCOUNT_WIDTH wide and clears on entry to COMMIT.
REQ-025 If pwm_en = 0 while in PEND, the FSM SHALL go to COMMIT in the next cycle regardless of maskmode or eventcount.
REQ-026 In COMMIT the block SHALL:
- load the active registers from the shadow set;
- pulse commit;
- return to IDLE, so outputs update one cycle after the commit decision.
REQ-027 When a transfer and a completing qualifying event occur in the same PEND cycle, the newly written shadow data SHALL be the data committed.
REQ-028 cfg_valid held during COMMIT SHALL be accepted in the following IDLE cycle; no set is ever dropped or duplicated.
REQ-029 act_carr_en SHALL be combinational on pwm_en and the registered act_period; act_period = 0 forces the carrier off.
REQ-030 carr_min/carr_max pulses in IDLE or COMMIT SHALL be ignored and SHALL NOT affect evt_cnt.
REQ-031 pending SHALL be 1 exactly when the state is PEND.

Reset
REQ-032 On reset = 1 at a rising edge, all of the following SHALL clear to 0 in the next cycle, aborting any pending set:
- state = IDLE, evt_cnt, the shadow set;
- act_period, act_compare, act_initcarr, act_countmode (COUNT_UP);
- act_carr_en, pending, commit, interrupt.
REQ-033 cfg_ready SHALL be 0 while reset is asserted and 1 in the first cycle after reset releases.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
- Basic commit: pwm_en = 1, transfer {period 2000, compare 500, UPDOWN, MIN_MASK, eventcount 0} -> pending = 1; commit/interrupt pulse one cycle after the next carr_min; act_period = 2000, act_carr_en = 1.
- Prescaler: eventcount = 1, MIN_MASK -> the first carr_min is ignored; commit follows the second carr_min; carr_max pulses are ignored throughout.
- Overwrite in PEND: a second transfer with period 1000 before the event -> act_period = 1000, a single commit pulse, evt_cnt not restarted.
- Period zero / stop: commit period 0 -> act_carr_en = 0. A transfer with pwm_en = 0 and MAX_MASK -> commit two cycles after the transfer.
- Backpressure and interrupt gating: cfg_valid held through COMMIT -> accepted the next cycle, pending reasserts. With int_en = 0 -> commit pulses and interrupt stays 0.
- Reset mid-PEND: assert reset while pending -> all outputs 0 the next cycle, and no commit occurs afterwards.
